// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: byte FIFO feeding an 8N1 serialiser with a programmable bit period.
// Define UART_TX_PARITY_EN to add the PARITY state and the parity_en/parity_odd ports (8E1/8O1).
module uart_tx_fifo #(
  parameter int DEPTH   = 16,
  parameter int PRESC_W = 16
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic                   en,
  input  logic [PRESC_W-1:0]     prescaler,
  input  logic [7:0]             wdata,
  input  logic                   wr,
`ifdef UART_TX_PARITY_EN
  input  logic                   parity_en,
  input  logic                   parity_odd,
`endif
  output logic                   tx,
  output logic                   busy,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic                   done
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t             state;
  logic [7:0]         mem [DEPTH];
  logic [AW-1:0]      wptr, rptr;
  logic [LW-1:0]      level_nxt;
  logic [PRESC_W-1:0] cnt, presc_q;
  logic [2:0]         idx;
  logic [7:0]         shreg;
  logic               bit_last, push, pop;
`ifdef UART_TX_PARITY_EN
  logic               par_on, par_q;
`endif

  assign bit_last  = (cnt == presc_q);
  assign push      = wr && !full;
  // STOP hands straight over to the next START so back-to-back frames have no gap.
  assign pop       = en && !empty && ((state == S_IDLE) || (state == S_STOP && bit_last));
  assign level_nxt = level + LW'(push) - LW'(pop);
  assign busy      = (state != S_IDLE);

  always_ff @(posedge HCLK)
    if (push) mem[wptr] <= wdata;

  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      wptr     <= '0;
      rptr     <= '0;
      level    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      level    <= level_nxt;
      full     <= (level_nxt == LW'(DEPTH));
      empty    <= (level_nxt == '0);
      overflow <= wr && full;
    end

  // tx/done are registered from the current state, so the line trails the FSM by one cycle.
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      state   <= S_IDLE;
      cnt     <= '0;
      presc_q <= '0;
      idx     <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
      done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_on  <= 1'b0;
      par_q   <= 1'b0;
`endif
    end else begin
      done <= (state == S_STOP) && bit_last;
      if (state == S_IDLE || bit_last) cnt <= '0;
      else                             cnt <= cnt + 1'b1;
      case (state)
        S_IDLE:  tx <= 1'b1;
        S_START: begin
          tx <= 1'b0;
          if (bit_last) state <= S_DATA;
        end
        S_DATA: begin
          tx <= shreg[0];
          if (bit_last) begin
            shreg <= {1'b0, shreg[7:1]};
            idx   <= idx + 3'd1;
            if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state <= par_on ? S_PARITY : S_STOP;
`else
              state <= S_STOP;
`endif
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          tx <= par_q;
          if (bit_last) state <= S_STOP;
        end
`endif
        S_STOP: begin
          tx <= 1'b1;
          if (bit_last) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
      if (pop) begin
        state   <= S_START;
        shreg   <= mem[rptr];
        presc_q <= prescaler;
        idx     <= '0;
`ifdef UART_TX_PARITY_EN
        par_on  <= parity_en;
        par_q   <= ^mem[rptr] ^ parity_odd;
`endif
      end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: reset, latency, framing, FIFO full/overflow, back-to-back,
// prescaler latching and mid-frame reset. Parity cases run only when UART_TX_PARITY_EN is defined.
module tb_uart_tx_fifo;
  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        en, wr;
  logic [15:0] prescaler;
  logic [7:0]  wdata;
`ifdef UART_TX_PARITY_EN
  logic        parity_en, parity_odd;
`endif
  logic        tx, busy, full, empty, overflow, done;
  logic [4:0]  level;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 HCLK = ~HCLK;

  uart_tx_fifo #(.DEPTH(16), .PRESC_W(16)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .en(en), .prescaler(prescaler),
    .wdata(wdata), .wr(wr),
`ifdef UART_TX_PARITY_EN
    .parity_en(parity_en), .parity_odd(parity_odd),
`endif
    .tx(tx), .busy(busy), .full(full), .empty(empty), .level(level),
    .overflow(overflow), .done(done)
  );

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  // Waits for the start bit, then checks every cycle of the frame against the expected bits.
  task automatic check_frame(input string nm, input logic [7:0] d, input int p,
                             input bit par_on, input bit par_bit, input int exp_wait,
                             input int chg_cyc, input logic [15:0] chg_val);
    logic [10:0] bits;
    logic [7:0]  rx;
    int nb, w, err, dn, dpos, k;
    nb = par_on ? 11 : 10;
    bits = '1;
    bits[0] = 1'b0;
    bits[8:1] = d;
    if (par_on) bits[9] = par_bit;
    w = 0;
    do begin tick(); w++; end while (tx !== 1'b0 && w < 400);
    n_cmp++;
    if (tx !== 1'b0 || w != exp_wait) begin
      n_bad++;
      $display("FAIL %s start: tx fell after %0d cycles (tx=%b), required after %0d", nm, w, tx, exp_wait);
      return;
    end
    err = 0; dn = 0; dpos = 0; rx = '0;
    for (int c = 1; c <= nb * (p + 1); c++) begin
      if (c > 1) tick();
      if (c == chg_cyc) prescaler = chg_val;
      k = (c - 1) / (p + 1);
      if (tx !== bits[k]) err++;
      if (done === 1'b1) begin dn++; dpos = c; end
      if ((c - 1) % (p + 1) == p / 2 && k >= 1 && k <= 8) rx[k-1] = tx;
    end
    n_cmp++;
    if (err != 0) begin
      n_bad++;
      $display("FAIL %s wave: %0d wrong cycles, got byte %02h, required byte %02h", nm, err, rx, d);
    end
    n_cmp++;
    if (dn != 1 || dpos != nb * (p + 1)) begin
      n_bad++;
      $display("FAIL %s done: %0d pulses at cycle %0d, required 1 at cycle %0d", nm, dn, dpos, nb * (p + 1));
    end
    if (rx >= 8'h20 && rx < 8'h7f) $display("terminal rx '%c' (%02h)", rx, rx);
    else                            $display("terminal rx %02h", rx);
  endtask

  task automatic write_byte(input logic [7:0] d);
    wr = 1'b1; wdata = d;
    tick();
    wr = 1'b0;
  endtask

  task automatic test_reset();
    HRESETn = 1'b0; en = 1'b0; wr = 1'b0; wdata = '0; prescaler = '0;
`ifdef UART_TX_PARITY_EN
    parity_en = 1'b0; parity_odd = 1'b0;
`endif
    tick(); tick();
    n_cmp++; if (tx !== 1'b1)      begin n_bad++; $display("FAIL rst tx: got %b, required 1", tx); end
    n_cmp++; if (busy !== 1'b0)    begin n_bad++; $display("FAIL rst busy: got %b, required 0", busy); end
    n_cmp++; if (full !== 1'b0)    begin n_bad++; $display("FAIL rst full: got %b, required 0", full); end
    n_cmp++; if (empty !== 1'b1)   begin n_bad++; $display("FAIL rst empty: got %b, required 1", empty); end
    n_cmp++; if (level !== 5'd0)   begin n_bad++; $display("FAIL rst level: got %0d, required 0", level); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL rst overflow: got %b, required 0", overflow); end
    n_cmp++; if (done !== 1'b0)    begin n_bad++; $display("FAIL rst done: got %b, required 0", done); end
    HRESETn = 1'b1;
    tick();
  endtask

  task automatic test_basic_frame();
    prescaler = 16'd15; en = 1'b1;
    write_byte(8'h55);
    n_cmp++; if (empty !== 1'b0) begin n_bad++; $display("FAIL lat empty: got %b, required 0", empty); end
    n_cmp++; if (level !== 5'd1) begin n_bad++; $display("FAIL lat level: got %0d, required 1", level); end
    check_frame("f55", 8'h55, 15, 1'b0, 1'b0, 2, 0, 16'd0);
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL f55 idle busy: got %b, required 0", busy); end
  endtask

  task automatic test_fast_frame();
    prescaler = 16'd0;
    write_byte(8'hA3);
    check_frame("fa3", 8'hA3, 0, 1'b0, 1'b0, 2, 0, 16'd0);
    tick();
  endtask

  task automatic test_full_overflow();
    en = 1'b0; prescaler = 16'd1;
    wr = 1'b1;
    for (int i = 0; i < 17; i++) begin
      wdata = 8'(i);
      tick();
      if (i == 15) begin
        n_cmp++; if (full !== 1'b1)     begin n_bad++; $display("FAIL ovf full16: got %b, required 1", full); end
        n_cmp++; if (level !== 5'd16)   begin n_bad++; $display("FAIL ovf level16: got %0d, required 16", level); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf early: got %b, required 0", overflow); end
      end
    end
    wr = 1'b0;
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf pulse: got %b, required 1", overflow); end
    n_cmp++; if (level !== 5'd16)   begin n_bad++; $display("FAIL ovf level17: got %0d, required 16", level); end
    en = 1'b1;
    tick();
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf width: got %b, required 0", overflow); end
    // The enabling tick already popped; the first start bit follows on the next cycle.
    check_frame("b2b0", 8'h00, 1, 1'b0, 1'b0, 1, 0, 16'd0);
    for (int i = 1; i < 16; i++)
      check_frame("b2b", 8'(i), 1, 1'b0, 1'b0, 1, 0, 16'd0);
    begin
      int hi = 0;
      for (int c = 0; c < 30; c++) begin tick(); if (tx === 1'b1) hi++; end
      n_cmp++; if (hi != 30)       begin n_bad++; $display("FAIL b2b extra: tx high %0d/30 cycles, required 30", hi); end
      n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL b2b empty: got %b, required 1", empty); end
    end
  endtask

  task automatic test_prescaler_change();
    prescaler = 16'd15;
    wr = 1'b1; wdata = 8'hC5;
    tick();
    wdata = 8'h3A;
    tick();
    wr = 1'b0;
    // Second write coincided with the first pop.
    n_cmp++; if (level !== 5'd1) begin n_bad++; $display("FAIL psc level: got %0d, required 1", level); end
    check_frame("psc16", 8'hC5, 15, 1'b0, 1'b0, 1, 40, 16'd3);
    check_frame("psc4", 8'h3A, 3, 1'b0, 1'b0, 1, 0, 16'd0);
    tick();
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    prescaler = 16'd2; parity_en = 1'b1; parity_odd = 1'b0;
    write_byte(8'h07);
    check_frame("par_even", 8'h07, 2, 1'b1, 1'b1, 2, 0, 16'd0);
    tick();
    parity_odd = 1'b1;
    write_byte(8'h07);
    check_frame("par_odd", 8'h07, 2, 1'b1, 1'b0, 2, 0, 16'd0);
    parity_en = 1'b0; parity_odd = 1'b0;
    tick();
  endtask
`endif

  task automatic test_reset_midframe();
    int w, hi;
    prescaler = 16'd3;
    wr = 1'b1; wdata = 8'h50;
    tick();
    wdata = 8'h3C;
    tick();
    wr = 1'b0;
    w = 0;
    while (tx !== 1'b0 && w < 100) begin tick(); w++; end
    // tx is now in start-bit cycle 1; cycle 18 lies inside data bit 3 (0 for 0x50).
    repeat (17) tick();
    n_cmp++; if (tx !== 1'b0) begin n_bad++; $display("FAIL mrst bit3: got %b, required 0", tx); end
    HRESETn = 1'b0;
    #1;
    n_cmp++; if (tx !== 1'b1)      begin n_bad++; $display("FAIL mrst tx: got %b, required 1", tx); end
    n_cmp++; if (busy !== 1'b0)    begin n_bad++; $display("FAIL mrst busy: got %b, required 0", busy); end
    n_cmp++; if (empty !== 1'b1)   begin n_bad++; $display("FAIL mrst empty: got %b, required 1", empty); end
    n_cmp++; if (level !== 5'd0)   begin n_bad++; $display("FAIL mrst level: got %0d, required 0", level); end
    tick(); tick();
    HRESETn = 1'b1;
    hi = 0;
    for (int c = 0; c < 60; c++) begin tick(); if (tx === 1'b1 && busy === 1'b0) hi++; end
    n_cmp++; if (hi != 60) begin n_bad++; $display("FAIL mrst after: idle %0d/60 cycles, required 60", hi); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_fast_frame();
    test_full_overflow();
    test_prescaler_change();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered UART transmitter for the SoC's APB/AHB UART subsystem: bytes written by the bus-side register logic are queued in an internal FIFO and serialised on `tx` as 8N1 frames (optionally 8E1/8O1) at a programmable bit period. It is the transmitting end of the serial link whose receiving end is the bench terminal model (LSB-first, idle-high, 1 start bit, 1 stop bit). One instance drives each `RsTx` pin.

## Interface
- `DEPTH`, 16, FIFO entries; power of two, 2..256
- `PRESC_W`, 16, width of the bit-period prescaler
- `HCLK` in 1: sole clock, all state on rising edge
- `HRESETn` in 1: asynchronous, active-low reset
- `en` in 1: transmitter enable; gates the start of new frames only
- `prescaler` in PRESC_W: bit period = prescaler+1 HCLK cycles
- `wdata` in 8: byte to enqueue
- `wr` in 1: enqueue strobe, one byte per cycle high
- `parity_en` in 1: insert parity bit (only with `UART_TX_PARITY_EN`)
- `parity_odd` in 1: 1 = odd, 0 = even parity (only with `UART_TX_PARITY_EN`)
- `tx` out 1: serial output, idle high
- `busy` out 1: frame in progress
- `full` out 1: FIFO level == DEPTH
- `empty` out 1: FIFO level == 0
- `level` out clog2(DEPTH)+1: FIFO occupancy
- `overflow` out 1: one-cycle pulse when a write is dropped
- `done` out 1: one-cycle pulse at end of each stop bit

## Operation
- FIFO: circular buffer, read/write pointers wrap modulo DEPTH; `full`/`empty`/`level` are registered and reflect the state after the previous edge.
- Write accepted iff `wr` && !`full` (registered `full`); a write while `full` is dropped and pulses `overflow`, even if a pop occurs in the same cycle. Simultaneous accepted write and pop leave `level` unchanged.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: if `en` && !`empty`, pop head byte into shift register, latch `prescaler` (and parity settings), go START. Otherwise `tx`=1.
- START: `tx`=0 for one bit period.
- DATA: 8 bits, LSB first, one bit period each; 3-bit index counter.
- PARITY (only if compiled in and latched `parity_en`=1): `tx` = XOR(data) ^ `parity_odd`.
- STOP: `tx`=1 for one bit period; on last cycle pulse `done`; if `en` && !`empty`, pop and go straight to START (no idle gap), else IDLE.
- Bit-period counter counts 0..latched prescaler; `prescaler` changes affect only the next frame. `prescaler`=0 gives 1 cycle/bit.
- Dropping `en` mid-frame: current frame completes, no further pops.
- `busy` = state != IDLE.

## Timing
- Reset values: `tx`=1, `busy`=0, `full`=0, `empty`=1, `level`=0, `overflow`=0, `done`=0; FIFO pointers 0; FSM IDLE.
- Reset asserted mid-frame: `tx` returns to 1 asynchronously, FIFO contents discarded.
- `tx` is a flop output (glitch-free).
- Latency: write at edge N into empty FIFO with `en`=1 and IDLE → `empty` low after N, pop at N+1, `tx` falls after edge N+2.
- Frame length = 10×(P+1) cycles (11×(P+1) with parity), P = latched prescaler.
- `done` high during the final cycle of STOP; back-to-back frame's start bit begins next cycle.

## Configuration
- `UART_TX_PARITY_EN` defined: PARITY state, `parity_en`, `parity_odd` ports present.
- Undefined: ports absent, PARITY state not synthesised, frames are always 8N1.

## Test plan
- Prescaler=15, write 0x55 → `tx` low 16 cycles, then 1,0,1,0,1,0,1,0 (16 cycles each), stop high 16 cycles; `done` pulse at frame cycle 160; bench terminal prints 'U'.
- Write 17 bytes 0x00..0x10 back-to-back with `en`=0, DEPTH=16 → `full`=1 after 16, 17th dropped with `overflow` pulse, `level`=16; enable → 16 contiguous frames, no idle gaps, 0x10 never sent.
- Prescaler=0, write 0xA3 → 10-cycle frame, bits 1,1,0,0,0,1,0,1.
- Parity build, `parity_en`=1, `parity_odd`=0, write 0x07 → parity bit 1; `parity_odd`=1 → 0; frame 11 bit periods.
- Change prescaler 15→3 mid-frame → current frame stays 16 cycles/bit, next frame 4 cycles/bit.
- Assert `HRESETn` low at DATA bit 3 → `tx`=1 immediately, `empty`=1, `busy`=0; no frame after release.
